// File: rtl/fix_rx_framer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fix_rx_framer
//
// Store-and-forward framing buffer between the TCP offload engine byte stream
// and the FIX engine parser. The input FSM hunts for "8=" and writes message
// bytes into a circular buffer with per-byte sof/eof flags. A message becomes
// visible to the reader only when its "10=ddd<SOH>" trailer has been written,
// by moving commit_ptr. A malformed, over-length or stuck message is discarded
// by pulling wr_ptr back to commit_ptr.
//
// Ports
//   clk           : single clock
//   rst           : asynchronous reset, active low
//   data_i        : received byte from the TOE
//   valid_i       : data_i valid, taken when ready_o is high
//   ready_o       : buffer has a free entry (combinational from pointers)
//   message_o     : byte to the FIX engine (registered)
//   msg_valid_o   : message_o valid
//   ready_i       : downstream takes message_o
//   new_message_o : first byte ("8") of a message
//   msg_end_o     : final SOH of a message
//   drop_o        : one-cycle pulse when a partial message is discarded
//   level_o       : occupied entries wr_ptr - rd_ptr, uncommitted ones included
// -----------------------------------------------------------------------------
module fix_rx_framer #(
  parameter int ADDR_W  = 6,
  parameter int MAX_MSG = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        data_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic [7:0]        message_o,
  output logic              msg_valid_o,
  input  logic              ready_i,
  output logic              new_message_o,
  output logic              msg_end_o,
  output logic              drop_o,
  output logic [ADDR_W:0]   level_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LEN_W = ADDR_W + 2;

  localparam logic [7:0] SOH   = 8'h01;
  localparam logic [7:0] CH_8  = 8'h38;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_1  = 8'h31;
  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_9  = 8'h39;

  localparam logic [ADDR_W:0]  PTR_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]  FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_MSG);

  typedef enum logic [1:0] {S_HUNT, S_BEGIN, S_BODY, S_CHK} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     commit_ptr_q, commit_ptr_d;
  logic [ADDR_W:0]     rd_ptr_q, rd_ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [23:0]         hist_q, hist_d;
  logic [1:0]          dcnt_q, dcnt_d;
  logic                drop_q, drop_d;
  logic [7:0]          msg_q, msg_d;
  logic                msg_valid_q, msg_valid_d;
  logic                new_q, new_d;
  logic                end_q, end_d;

  logic [9:0]          mem [DEPTH];
  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [9:0]          wdata;

  logic [ADDR_W:0]     level;
  logic                full;
  logic                accept;
  logic                is_digit;
  logic                len_ok;
  logic                stuck;
  logic                load;
  logic [9:0]          rd_entry;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign full     = (level == FULL_LVL);
  assign accept   = valid_i && !full;
  assign is_digit = (data_i >= CH_0) && (data_i <= CH_9);
  // A further write is allowed only while the message is below MAX_MSG.
  assign len_ok   = (len_q < MAX_LEN);
  // Buffer full of a single unfinished message: nothing can ever drain it.
  assign stuck    = full && (commit_ptr_q == rd_ptr_q);

  // Input FSM: decides the write, pointer moves and rollbacks.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    hist_d       = hist_q;
    dcnt_d       = dcnt_q;
    drop_d       = 1'b0;
    we           = 1'b0;
    waddr        = wr_ptr_q[ADDR_W-1:0];
    wdata        = {2'b00, data_i};

    if (stuck) begin
      wr_ptr_d = commit_ptr_q;
      drop_d   = 1'b1;
      len_d    = '0;
      state_d  = S_HUNT;
    end else if (accept) begin
      case (state_q)
        S_HUNT: begin
          if (data_i == CH_8) begin
            we       = 1'b1;
            wdata    = {1'b0, 1'b1, data_i};
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = LEN_ONE;
            hist_d   = {16'h0000, data_i};
            state_d  = S_BEGIN;
          end
        end

        S_BEGIN: begin
          if (data_i == CH_EQ && len_ok) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = len_q + LEN_ONE;
            hist_d   = {hist_q[15:0], data_i};
            state_d  = S_BODY;
          end else if (data_i == CH_8) begin
            // Discard the stale "8" and restart a message in its place.
            drop_d   = 1'b1;
            we       = 1'b1;
            waddr    = commit_ptr_q[ADDR_W-1:0];
            wdata    = {1'b0, 1'b1, data_i};
            wr_ptr_d = commit_ptr_q + PTR_ONE;
            len_d    = LEN_ONE;
            hist_d   = {16'h0000, data_i};
          end else begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
            len_d    = '0;
            state_d  = S_HUNT;
          end
        end

        S_BODY: begin
          if (len_ok) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = len_q + LEN_ONE;
            hist_d   = {hist_q[15:0], data_i};
            if ({hist_q, data_i} == {SOH, CH_1, CH_0, CH_EQ}) begin
              dcnt_d  = 2'd0;
              state_d = S_CHK;
            end
          end else begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
            len_d    = '0;
            state_d  = S_HUNT;
          end
        end

        default: begin // S_CHK
          if (is_digit && dcnt_q != 2'd3 && len_ok) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            len_d    = len_q + LEN_ONE;
            dcnt_d   = dcnt_q + 2'd1;
          end else if (data_i == SOH && dcnt_q == 2'd3 && len_ok) begin
            // Final SOH: write it and publish the whole message.
            we           = 1'b1;
            wdata        = {1'b1, 1'b0, data_i};
            wr_ptr_d     = wr_ptr_q + PTR_ONE;
            commit_ptr_d = wr_ptr_q + PTR_ONE;
            len_d        = '0;
            state_d      = S_HUNT;
          end else begin
            wr_ptr_d = commit_ptr_q;
            drop_d   = 1'b1;
            len_d    = '0;
            state_d  = S_HUNT;
          end
        end
      endcase
    end
  end

  // Output register: refills whenever it is empty or being consumed.
  assign rd_entry = mem[rd_ptr_q[ADDR_W-1:0]];
  assign load     = (!msg_valid_q || ready_i) && (rd_ptr_q != commit_ptr_q);

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    msg_d       = msg_q;
    msg_valid_d = msg_valid_q;
    new_d       = new_q;
    end_d       = end_q;
    if (load) begin
      msg_d       = rd_entry[7:0];
      new_d       = rd_entry[8];
      end_d       = rd_entry[9];
      msg_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + PTR_ONE;
    end else if (ready_i) begin
      msg_valid_d = 1'b0;
      new_d       = 1'b0;
      end_d       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_HUNT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      dcnt_q       <= '0;
      drop_q       <= 1'b0;
      msg_q        <= '0;
      msg_valid_q  <= 1'b0;
      new_q        <= 1'b0;
      end_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      dcnt_q       <= dcnt_d;
      drop_q       <= drop_d;
      msg_q        <= msg_d;
      msg_valid_q  <= msg_valid_d;
      new_q        <= new_d;
      end_q        <= end_d;
    end
  end

  // Storage and trailer history carry no reset; pointers define validity.
  always_ff @(posedge clk) begin
    hist_q <= hist_d;
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign ready_o       = !full;
  assign message_o     = msg_q;
  assign msg_valid_o   = msg_valid_q;
  assign new_message_o = new_q;
  assign msg_end_o     = end_q;
  assign drop_o        = drop_q;
  assign level_o       = level;

endmodule

// File: tb/tb_fix_rx_framer.sv
`timescale 1ns/1ps
// Testbench for fix_rx_framer. Three instances share the input stimulus:
// dut0 uses default parameters, dut1 has MAX_MSG=16, dut2 has ADDR_W=4 and
// MAX_MSG=16. Bytes written as '|' in the message strings stand for SOH.
module tb_fix_rx_framer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b1;

  logic r0, v0, n0, e0, d0; logic [7:0] m0; logic [6:0] l0;
  logic r1, v1, n1, e1, d1; logic [7:0] m1; logic [6:0] l1;
  logic r2, v2, n2, e2, d2; logic [7:0] m2; logic [4:0] l2;

  int compared   = 0;
  int mismatched = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];
  int drops0 = 0, drops1 = 0, drops2 = 0;

  localparam string CLEAN = "8=FIX.4.2|9=5|35=0|10=123|";

  fix_rx_framer dut0 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(r0),
    .message_o(m0), .msg_valid_o(v0), .ready_i(ready_i), .new_message_o(n0),
    .msg_end_o(e0), .drop_o(d0), .level_o(l0)
  );

  fix_rx_framer #(.ADDR_W(6), .MAX_MSG(16)) dut1 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(r1),
    .message_o(m1), .msg_valid_o(v1), .ready_i(ready_i), .new_message_o(n1),
    .msg_end_o(e1), .drop_o(d1), .level_o(l1)
  );

  fix_rx_framer #(.ADDR_W(4), .MAX_MSG(16)) dut2 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ready_o(r2),
    .message_o(m2), .msg_valid_o(v2), .ready_i(ready_i), .new_message_o(n2),
    .msg_end_o(e2), .drop_o(d2), .level_o(l2)
  );

  always #5 clk = ~clk;

  // Record every downstream handshake and drop pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (v0 && ready_i) q0.push_back({e0, n0, m0});
      if (v1 && ready_i) q1.push_back({e1, n1, m1});
      if (v2 && ready_i) q2.push_back({e2, n2, m2});
      if (d0) drops0++;
      if (d1) drops1++;
      if (d2) drops2++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] ch(input string s, input int i);
    logic [7:0] b;
    b = s[i];
    return (b == 8'h7C) ? 8'h01 : b;
  endfunction

  task automatic do_reset();
    valid_i = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present one byte and hold it until dut0 takes it (bounded).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (r0 !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) begin
      compared++; mismatched++;
      $display("FAIL send_timeout: ready_o got %b want 1", r0);
    end
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic send_str(input string s, input int from, input int to);
    for (int i = from; i < to; i++) send_byte(ch(s, i));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2;
    compared++; if (v0 !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", v0); end
    compared++; if (n0 !== 1'b0) begin mismatched++; $display("FAIL reset_new: got %b want 0", n0); end
    compared++; if (e0 !== 1'b0) begin mismatched++; $display("FAIL reset_end: got %b want 0", e0); end
    compared++; if (d0 !== 1'b0) begin mismatched++; $display("FAIL reset_drop: got %b want 0", d0); end
    compared++; if (m0 !== 8'h00) begin mismatched++; $display("FAIL reset_msg: got %h want 00", m0); end
    compared++; if (l0 !== 7'd0) begin mismatched++; $display("FAIL reset_level: got %0d want 0", l0); end
    compared++; if (r0 !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", r0); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_clean();
    int base, dr;
    logic [9:0] exp;
    do_reset();
    ready_i = 1'b1;
    base = q0.size(); dr = drops0;
    send_str(CLEAN, 0, 26);
    compared++; if (v0 !== 1'b0) begin mismatched++; $display("FAIL clean_latency_early: valid got %b want 0", v0); end
    @(posedge clk); #1;
    compared++; if (v0 !== 1'b1) begin mismatched++; $display("FAIL clean_latency: valid got %b want 1", v0); end
    compared++; if ({n0, m0} !== {1'b1, 8'h38}) begin mismatched++; $display("FAIL clean_first: got %h want 138", {n0, m0}); end
    for (int k = 0; k < 200 && q0.size() < base + 26; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    compared++; if (q0.size() !== base + 26) begin mismatched++; $display("FAIL clean_count: got %0d want 26", q0.size() - base); end
    for (int i = 0; i < 26; i++) begin
      exp = {(i == 25), (i == 0), ch(CLEAN, i)};
      compared++; if (q0[base + i] !== exp) begin mismatched++; $display("FAIL clean_byte[%0d]: got %h want %h", i, q0[base + i], exp); end
    end
    compared++; if (drops0 !== dr) begin mismatched++; $display("FAIL clean_drop: got %0d want 0", drops0 - dr); end
  endtask

  task automatic test_garbage();
    int base, dr;
    logic [9:0] exp;
    string want;
    want = "8=A|10=007|";
    do_reset();
    ready_i = 1'b1;
    base = q0.size(); dr = drops0;
    send_str("xy8Q88=A|10=007|", 0, 16);
    for (int k = 0; k < 100 && q0.size() < base + 11; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    compared++; if (q0.size() !== base + 11) begin mismatched++; $display("FAIL garbage_count: got %0d want 11", q0.size() - base); end
    for (int i = 0; i < 11; i++) begin
      exp = {(i == 10), (i == 0), ch(want, i)};
      compared++; if (q0[base + i] !== exp) begin mismatched++; $display("FAIL garbage_byte[%0d]: got %h want %h", i, q0[base + i], exp); end
    end
    compared++; if (drops0 == dr) begin mismatched++; $display("FAIL garbage_drop: got %0d want nonzero", drops0 - dr); end
    compared++; if (l0 !== 7'd0) begin mismatched++; $display("FAIL garbage_level: got %0d want 0", l0); end
  endtask

  task automatic test_false_start();
    int base, dr;
    logic [9:0] exp;
    string want;
    want = "8=B|10=999|";
    do_reset();
    ready_i = 1'b1;
    base = q0.size(); dr = drops0;
    send_str("8Q8=B|10=999|", 0, 13);
    for (int k = 0; k < 100 && q0.size() < base + 11; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    compared++; if (q0.size() !== base + 11) begin mismatched++; $display("FAIL false_start_count: got %0d want 11", q0.size() - base); end
    for (int i = 0; i < 11; i++) begin
      exp = {(i == 10), (i == 0), ch(want, i)};
      compared++; if (q0[base + i] !== exp) begin mismatched++; $display("FAIL false_start_byte[%0d]: got %h want %h", i, q0[base + i], exp); end
    end
    compared++; if (drops0 - dr !== 1) begin mismatched++; $display("FAIL false_start_drop: got %0d want 1", drops0 - dr); end
  endtask

  task automatic test_bad_trailer();
    int base, dr;
    logic [9:0] exp;
    do_reset();
    ready_i = 1'b1;
    base = q0.size(); dr = drops0;
    send_str("8=A|10=1Z|", 0, 10);
    send_str(CLEAN, 0, 26);
    for (int k = 0; k < 200 && q0.size() < base + 26; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    compared++; if (q0.size() !== base + 26) begin mismatched++; $display("FAIL bad_trailer_count: got %0d want 26", q0.size() - base); end
    for (int i = 0; i < 26; i++) begin
      exp = {(i == 25), (i == 0), ch(CLEAN, i)};
      compared++; if (q0[base + i] !== exp) begin mismatched++; $display("FAIL bad_trailer_byte[%0d]: got %h want %h", i, q0[base + i], exp); end
    end
    compared++; if (drops0 - dr !== 1) begin mismatched++; $display("FAIL bad_trailer_drop: got %0d want 1", drops0 - dr); end
    compared++; if (l0 !== 7'd0) begin mismatched++; $display("FAIL bad_trailer_level: got %0d want 0", l0); end
  endtask

  task automatic test_backpressure();
    int base, dr;
    logic [9:0] exp;
    do_reset();
    ready_i = 1'b0;
    base = q0.size(); dr = drops0;
    // 65 bytes in; the first one sits in the output register.
    send_str(CLEAN, 0, 26);
    send_str(CLEAN, 0, 26);
    send_str(CLEAN, 0, 13);
    compared++; if (l0 !== 7'd64) begin mismatched++; $display("FAIL bp_level_full: got %0d want 64", l0); end
    compared++; if (r0 !== 1'b0) begin mismatched++; $display("FAIL bp_ready_full: got %b want 0", r0); end
    for (int c = 0; c < 10; c++) begin
      compared++; if ({v0, e0, n0, m0} !== {1'b1, 1'b0, 1'b1, 8'h38}) begin mismatched++; $display("FAIL bp_hold[%0d]: got %h want 538", c, {v0, e0, n0, m0}); end
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    send_str(CLEAN, 13, 26);
    for (int k = 0; k < 300 && q0.size() < base + 78; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    compared++; if (q0.size() !== base + 78) begin mismatched++; $display("FAIL bp_count: got %0d want 78", q0.size() - base); end
    for (int i = 0; i < 78; i++) begin
      exp = {((i % 26) == 25), ((i % 26) == 0), ch(CLEAN, i % 26)};
      compared++; if (q0[base + i] !== exp) begin mismatched++; $display("FAIL bp_byte[%0d]: got %h want %h", i, q0[base + i], exp); end
    end
    compared++; if (l0 !== 7'd0) begin mismatched++; $display("FAIL bp_level_end: got %0d want 0", l0); end
    compared++; if (drops0 !== dr) begin mismatched++; $display("FAIL bp_drop: got %0d want 0", drops0 - dr); end
  endtask

  task automatic test_overlength();
    int base, dr;
    logic [9:0] exp;
    string lng, sht;
    lng = "8=ABCDEFGHIJ|10=123|";
    sht = "8=AB|10=456|";
    do_reset();
    ready_i = 1'b1;
    base = q1.size(); dr = drops1;
    send_str(lng, 0, 16);
    compared++; if (l1 !== 7'd16) begin mismatched++; $display("FAIL ovl_level16: got %0d want 16", l1); end
    compared++; if (r1 !== 1'b1) begin mismatched++; $display("FAIL ovl_ready16: got %b want 1", r1); end
    compared++; if (d1 !== 1'b0) begin mismatched++; $display("FAIL ovl_early_drop: got %b want 0", d1); end
    send_byte(ch(lng, 16));
    compared++; if (d1 !== 1'b1) begin mismatched++; $display("FAIL ovl_drop17: got %b want 1", d1); end
    compared++; if (l1 !== 7'd0) begin mismatched++; $display("FAIL ovl_level17: got %0d want 0", l1); end
    send_str(lng, 17, 20);
    send_str(sht, 0, 12);
    for (int k = 0; k < 100 && q1.size() < base + 12; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    compared++; if (q1.size() !== base + 12) begin mismatched++; $display("FAIL ovl_count: got %0d want 12", q1.size() - base); end
    for (int i = 0; i < 12; i++) begin
      exp = {(i == 11), (i == 0), ch(sht, i)};
      compared++; if (q1[base + i] !== exp) begin mismatched++; $display("FAIL ovl_byte[%0d]: got %h want %h", i, q1[base + i], exp); end
    end
    compared++; if (drops1 - dr !== 1) begin mismatched++; $display("FAIL ovl_drops: got %0d want 1", drops1 - dr); end
  endtask

  task automatic test_deadlock();
    int base;
    do_reset();
    ready_i = 1'b1;
    base = q2.size();
    send_str("8=ABCDEFGHIJKLMN", 0, 16);
    compared++; if (r2 !== 1'b0) begin mismatched++; $display("FAIL dl_ready_full: got %b want 0", r2); end
    compared++; if (l2 !== 5'd16) begin mismatched++; $display("FAIL dl_level_full: got %0d want 16", l2); end
    @(posedge clk); #1;
    compared++; if (d2 !== 1'b1) begin mismatched++; $display("FAIL dl_drop: got %b want 1", d2); end
    compared++; if (r2 !== 1'b1) begin mismatched++; $display("FAIL dl_ready_back: got %b want 1", r2); end
    compared++; if (l2 !== 5'd0) begin mismatched++; $display("FAIL dl_level_back: got %0d want 0", l2); end
    repeat (3) @(posedge clk); #1;
    compared++; if (q2.size() !== base) begin mismatched++; $display("FAIL dl_output: got %0d want 0", q2.size() - base); end
  endtask

  task automatic test_async_reset();
    int base;
    logic [9:0] exp;
    do_reset();
    ready_i = 1'b0;
    send_str("8=AB|10=456|", 0, 12);
    send_str(CLEAN, 0, 5);
    compared++; if ({v0, l0} !== {1'b1, 7'd16}) begin mismatched++; $display("FAIL ar_pre: got %h want 90", {v0, l0}); end
    #3;
    rst = 1'b0;
    #1;
    compared++; if (v0 !== 1'b0) begin mismatched++; $display("FAIL ar_valid: got %b want 0", v0); end
    compared++; if (n0 !== 1'b0) begin mismatched++; $display("FAIL ar_new: got %b want 0", n0); end
    compared++; if (e0 !== 1'b0) begin mismatched++; $display("FAIL ar_end: got %b want 0", e0); end
    compared++; if (m0 !== 8'h00) begin mismatched++; $display("FAIL ar_msg: got %h want 00", m0); end
    compared++; if (l0 !== 7'd0) begin mismatched++; $display("FAIL ar_level: got %0d want 0", l0); end
    compared++; if (r0 !== 1'b1) begin mismatched++; $display("FAIL ar_ready: got %b want 1", r0); end
    @(posedge clk); #1;
    rst = 1'b1;
    ready_i = 1'b1;
    @(posedge clk); #1;
    base = q0.size();
    send_str(CLEAN, 0, 26);
    for (int k = 0; k < 200 && q0.size() < base + 26; k++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    compared++; if (q0.size() !== base + 26) begin mismatched++; $display("FAIL ar_count: got %0d want 26", q0.size() - base); end
    for (int i = 0; i < 26; i++) begin
      exp = {(i == 25), (i == 0), ch(CLEAN, i)};
      compared++; if (q0[base + i] !== exp) begin mismatched++; $display("FAIL ar_byte[%0d]: got %h want %h", i, q0[base + i], exp); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_garbage();
    test_false_start();
    test_bad_trailer();
    test_backpressure();
    test_overlength();
    test_deadlock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
